// File: rtl/prll_bs_drvr_fifo.sv
// Per-driver drop FIFO pair for the parallel bus arbiter: TX queue toward the arbiter and
// an address-filtered RX queue toward the host, with shared overflow/underflow status.
module prll_bs_drvr_fifo #(
    parameter int          bits      = 32,
    parameter int          depth     = 16,
    parameter logic [7:0]  ID        = 8'h00,
    parameter logic [7:0]  broadcast = {8{1'b1}},
    localparam int         CW        = $clog2(depth + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tx_wr,
    input  logic [bits-1:0] tx_data,
    output logic            tx_full,
    output logic [CW-1:0]   tx_count,
    output logic            pndng,
    input  logic            pop,
    output logic [bits-1:0] D_pop,
    input  logic            push,
    input  logic [bits-1:0] D_push,
    input  logic            rx_rd,
    output logic [bits-1:0] rx_data,
    output logic            rx_vld,
    output logic [CW-1:0]   rx_count,
    output logic [7:0]      ovrflw_cnt,
    output logic            undrflw,
    input  logic            clr_err
);

    localparam int AW = $clog2(depth);

    logic [bits-1:0] tx_mem [depth];
    logic [AW-1:0]   tx_wr_ptr;
    logic [AW-1:0]   tx_rd_ptr;
    logic [CW-1:0]   tx_cnt;
    logic            tx_wr_en;
    logic            tx_rd_en;
    logic            tx_drop;
    logic            tx_unf;

    logic [bits-1:0] rx_mem [depth];
    logic [AW-1:0]   rx_wr_ptr;
    logic [AW-1:0]   rx_rd_ptr;
    logic [CW-1:0]   rx_cnt;
    logic            rx_full;
    logic            rx_match;
    logic            rx_wr_en;
    logic            rx_rd_en;
    logic            rx_drop;
    logic            rx_unf;
    logic [7:0]      dest;

    logic [8:0]      ovf_sum;

    // ---------------- TX queue ----------------
    assign tx_full  = (tx_cnt == CW'(depth));
    assign pndng    = (tx_cnt != '0);
    assign tx_count = tx_cnt;

    // A pop in the same cycle frees a slot, so a write to a full queue still lands.
    assign tx_rd_en = pop & pndng;
    assign tx_wr_en = tx_wr & (~tx_full | tx_rd_en);
    assign tx_drop  = tx_wr & ~tx_wr_en;
    assign tx_unf   = pop & ~pndng;

    always_ff @(posedge clk) begin
        if (tx_wr_en) begin
            tx_mem[tx_wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_cnt    <= '0;
        end else begin
            if (tx_wr_en) begin
                tx_wr_ptr <= tx_wr_ptr + AW'(1);
            end
            if (tx_rd_en) begin
                tx_rd_ptr <= tx_rd_ptr + AW'(1);
            end
            if (tx_wr_en && !tx_rd_en) begin
                tx_cnt <= tx_cnt + CW'(1);
            end else if (!tx_wr_en && tx_rd_en) begin
                tx_cnt <= tx_cnt - CW'(1);
            end
        end
    end

    assign D_pop = pndng ? tx_mem[tx_rd_ptr] : '0;

    // ---------------- RX queue ----------------
    assign dest     = D_push[bits-1 -: 8];
    assign rx_match = push & ((dest == ID) | (dest == broadcast));
    assign rx_full  = (rx_cnt == CW'(depth));
    assign rx_vld   = (rx_cnt != '0);
    assign rx_count = rx_cnt;

    assign rx_rd_en = rx_rd & rx_vld;
    assign rx_wr_en = rx_match & (~rx_full | rx_rd_en);
    assign rx_drop  = rx_match & ~rx_wr_en;
    assign rx_unf   = rx_rd & ~rx_vld;

    always_ff @(posedge clk) begin
        if (rx_wr_en) begin
            rx_mem[rx_wr_ptr] <= D_push;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_cnt    <= '0;
        end else begin
            if (rx_wr_en) begin
                rx_wr_ptr <= rx_wr_ptr + AW'(1);
            end
            if (rx_rd_en) begin
                rx_rd_ptr <= rx_rd_ptr + AW'(1);
            end
            if (rx_wr_en && !rx_rd_en) begin
                rx_cnt <= rx_cnt + CW'(1);
            end else if (!rx_wr_en && rx_rd_en) begin
                rx_cnt <= rx_cnt - CW'(1);
            end
        end
    end

    assign rx_data = rx_vld ? rx_mem[rx_rd_ptr] : '0;

    // ---------------- Error status ----------------
    // Nine-bit sum lets a double drop from 8'hFE or 8'hFF be detected and clamped.
    assign ovf_sum = {1'b0, ovrflw_cnt} + 9'(tx_drop) + 9'(rx_drop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovrflw_cnt <= '0;
            undrflw    <= 1'b0;
        end else if (clr_err) begin
            ovrflw_cnt <= '0;
            undrflw    <= 1'b0;
        end else begin
            ovrflw_cnt <= ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
            if (tx_unf || rx_unf) begin
                undrflw <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prll_bs_drvr_fifo.sv
// Randomized and directed bench for prll_bs_drvr_fifo, checked every cycle against a
// queue-based model of the two drop FIFOs and the error counters.
module tb_prll_bs_drvr_fifo;

    localparam int W  = 32;
    localparam int D  = 16;
    localparam int CW = $clog2(D + 1);

    logic          clk;
    logic          reset;
    logic          tx_wr;
    logic [W-1:0]  tx_data;
    logic          tx_full;
    logic [CW-1:0] tx_count;
    logic          pndng;
    logic          pop;
    logic [W-1:0]  D_pop;
    logic          push;
    logic [W-1:0]  D_push;
    logic          rx_rd;
    logic [W-1:0]  rx_data;
    logic          rx_vld;
    logic [CW-1:0] rx_count;
    logic [7:0]    ovrflw_cnt;
    logic          undrflw;
    logic          clr_err;

    int n_chk  = 0;
    int n_fail = 0;

    prll_bs_drvr_fifo #(
        .bits(W), .depth(D), .ID(8'h03), .broadcast(8'hFF)
    ) dut (
        .clk(clk), .reset(reset),
        .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full), .tx_count(tx_count),
        .pndng(pndng), .pop(pop), .D_pop(D_pop),
        .push(push), .D_push(D_push), .rx_rd(rx_rd), .rx_data(rx_data),
        .rx_vld(rx_vld), .rx_count(rx_count),
        .ovrflw_cnt(ovrflw_cnt), .undrflw(undrflw), .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: plain queues and integer counters.
    logic [W-1:0] m_tx[$];
    logic [W-1:0] m_rx[$];
    int           m_ovf;
    bit           m_unf;

    always @(posedge clk or negedge reset) begin : mdl
        int  drops;
        bit  unf_ev;
        bit  tx_po;
        bit  tx_ok;
        bit  rx_po;
        bit  rx_ok;
        bit  hit;
        if (!reset) begin
            m_tx.delete();
            m_rx.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            drops  = 0;
            unf_ev = 0;
            tx_po  = pop && (m_tx.size() > 0);
            tx_ok  = tx_wr && ((m_tx.size() < D) || tx_po);
            if (tx_wr && !tx_ok) drops++;
            if (pop && m_tx.size() == 0) unf_ev = 1;
            hit    = push && (D_push[31:24] == 8'h03 || D_push[31:24] == 8'hFF);
            rx_po  = rx_rd && (m_rx.size() > 0);
            rx_ok  = hit && ((m_rx.size() < D) || rx_po);
            if (hit && !rx_ok) drops++;
            if (rx_rd && m_rx.size() == 0) unf_ev = 1;
            if (tx_po) void'(m_tx.pop_front());
            if (tx_ok) m_tx.push_back(tx_data);
            if (rx_po) void'(m_rx.pop_front());
            if (rx_ok) m_rx.push_back(D_push);
            if (clr_err) begin
                m_ovf = 0;
                m_unf = 0;
            end else begin
                m_ovf = (m_ovf + drops > 255) ? 255 : m_ovf + drops;
                if (unf_ev) m_unf = 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("pndng",      pndng,      m_tx.size() != 0);
        chk("tx_full",    tx_full,    m_tx.size() == D);
        chk("tx_count",   tx_count,   m_tx.size());
        chk("D_pop",      D_pop,      (m_tx.size() != 0) ? m_tx[0] : 32'd0);
        chk("rx_vld",     rx_vld,     m_rx.size() != 0);
        chk("rx_count",   rx_count,   m_rx.size());
        chk("rx_data",    rx_data,    (m_rx.size() != 0) ? m_rx[0] : 32'd0);
        chk("ovrflw_cnt", ovrflw_cnt, m_ovf);
        chk("undrflw",    undrflw,    m_unf);
    end

    task automatic drive(input bit twr, input logic [W-1:0] td, input bit p,
                         input bit ps, input logic [W-1:0] dp, input bit rd, input bit clr);
        tx_wr   = twr;
        tx_data = td;
        pop     = p;
        push    = ps;
        D_push  = dp;
        rx_rd   = rd;
        clr_err = clr;
        @(posedge clk);
        #1;
        tx_wr   = 0;
        pop     = 0;
        push    = 0;
        rx_rd   = 0;
        clr_err = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pndng"},  pndng,      0);
        chk({tag, "_D_pop"},  D_pop,      0);
        chk({tag, "_txcnt"},  tx_count,   0);
        chk({tag, "_txfull"}, tx_full,    0);
        chk({tag, "_rxvld"},  rx_vld,     0);
        chk({tag, "_rxdata"}, rx_data,    0);
        chk({tag, "_rxcnt"},  rx_count,   0);
        chk({tag, "_ovf"},    ovrflw_cnt, 0);
        chk({tag, "_unf"},    undrflw,    0);
    endtask

    initial begin
        reset = 0; tx_wr = 0; tx_data = 0; pop = 0; push = 0; D_push = 0;
        rx_rd = 0; clr_err = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("rst");
        reset = 1;
        drive(0, 0, 0, 0, 0, 0, 0);

        // T1: three words, show-ahead order
        drive(1, 32'hAAAA_0001, 0, 0, 0, 0, 0);
        chk("t1_pndng", pndng, 1);
        chk("t1_dpop_a", D_pop, 32'hAAAA_0001);
        drive(1, 32'hBBBB_0002, 0, 0, 0, 0, 0);
        drive(1, 32'hCCCC_0003, 0, 0, 0, 0, 0);
        chk("t1_cnt", tx_count, 3);
        chk("t1_mdl_size", m_tx.size(), 3);
        drive(0, 0, 1, 0, 0, 0, 0);
        chk("t1_dpop_b", D_pop, 32'hBBBB_0002);
        drive(0, 0, 1, 0, 0, 0, 0);
        chk("t1_dpop_c", D_pop, 32'hCCCC_0003);
        drive(0, 0, 1, 0, 0, 0, 0);
        chk("t1_empty", pndng, 0);
        chk("t1_dpop_0", D_pop, 0);

        // T2: fill, overflow by one, drain in order
        for (int i = 1; i <= D; i++) drive(1, i, 0, 0, 0, 0, 0);
        chk("t2_full_pre", tx_full, 1);
        drive(1, 32'h99, 0, 0, 0, 0, 0);
        chk("t2_full", tx_full, 1);
        chk("t2_cnt", tx_count, 16);
        chk("t2_ovf", ovrflw_cnt, 1);
        for (int i = 1; i <= D; i++) begin
            chk("t2_order", D_pop, i);
            drive(0, 0, 1, 0, 0, 0, 0);
        end
        chk("t2_drained", pndng, 0);

        // T3: write and pop together while full
        for (int i = 1; i <= D; i++) drive(1, i, 0, 0, 0, 0, 0);
        drive(1, 32'h77, 1, 0, 0, 0, 0);
        chk("t3_cnt", tx_count, 16);
        chk("t3_ovf", ovrflw_cnt, 1);
        for (int i = 2; i <= D; i++) begin
            chk("t3_order", D_pop, i);
            drive(0, 0, 1, 0, 0, 0, 0);
        end
        chk("t3_last", D_pop, 32'h77);
        drive(0, 0, 1, 0, 0, 0, 0);

        // T4: address filter
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 32'h0300_0001, 0, 0);
        drive(0, 0, 0, 1, 32'h0500_0002, 0, 0);
        drive(0, 0, 0, 1, 32'hFF00_0003, 0, 0);
        chk("t4_cnt", rx_count, 2);
        chk("t4_head", rx_data, 32'h0300_0001);
        drive(0, 0, 0, 0, 0, 1, 0);
        chk("t4_bcast", rx_data, 32'hFF00_0003);
        drive(0, 0, 0, 0, 0, 1, 0);
        chk("t4_empty", rx_vld, 0);
        chk("t4_ovf", ovrflw_cnt, 0);

        // T5: underflow is sticky and cleared by clr_err
        drive(0, 0, 1, 0, 0, 0, 0);
        chk("t5_unf", undrflw, 1);
        chk("t5_cnt", tx_count, 0);
        drive(1, 32'h55, 0, 0, 0, 0, 0);
        chk("t5_dpop", D_pop, 32'h55);
        chk("t5_unf_hold", undrflw, 1);
        drive(0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("t5_clr_unf", undrflw, 0);
        chk("t5_clr_ovf", ovrflw_cnt, 0);

        // T6: saturation, then async reset mid-burst
        for (int i = 0; i < 3; i++) drive(1, 32'h600 + i, 0, 0, 0, 0, 0);
        for (int i = 0; i < D; i++) drive(0, 0, 0, 1, 32'h0300_0000 + i, 0, 0);
        chk("t6_rxfull", rx_count, 16);
        for (int i = 1; i <= 300; i++) begin
            drive(0, 0, 0, 1, 32'hFF00_1000 + i, 0, 0);
            if (i == 254) chk("t6_ovf_fe", ovrflw_cnt, 8'hFE);
        end
        chk("t6_ovf_sat", ovrflw_cnt, 8'hFF);
        chk("t6_mdl_ovf", m_ovf, 255);
        push   = 1;
        D_push = 32'hFF00_2000;
        @(posedge clk);
        #3;
        reset = 0;
        #1;
        chk_all_zero("t6_arst");
        push = 0;
        @(posedge clk);
        #1;
        reset = 1;
        drive(0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic in write-heavy and read-heavy phases
        for (int ph = 0; ph < 6; ph++) begin
            int wp;
            wp = (ph % 2 == 0) ? 75 : 25;
            for (int c = 0; c < 400; c++) begin
                logic [7:0] dst;
                case ($urandom_range(0, 3))
                    0: dst = 8'h03;
                    1: dst = 8'hFF;
                    2: dst = 8'h05;
                    default: dst = 8'($urandom);
                endcase
                drive($urandom_range(0, 99) < wp, $urandom,
                      $urandom_range(0, 99) < (100 - wp),
                      $urandom_range(0, 99) < wp, {dst, 24'($urandom)},
                      $urandom_range(0, 99) < (100 - wp),
                      $urandom_range(0, 99) < 2);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
